// File: rtl/bpsk_frame_tx.sv
// BPSK frame transmitter: preamble, sync word and payload bytes serialised at BIT_PERIOD clocks per bit.
// Optional feature macro FRAMER_CRC8_EN appends a CRC-8 (poly 0x07, init 0x00) byte after the payload.
module bpsk_frame_tx #(
  parameter int          BIT_PERIOD   = 20,
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [15:0] SYNC_WORD    = 16'hD391
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       bit_data_out,
  output logic       bit_data_en,
  output logic       busy,
  output logic       underrun
);
  localparam logic [11:0] BIT_LAST = 12'(BIT_PERIOD - 1);
  localparam logic [6:0]  PRE_LAST = 7'(PREAMBLE_LEN - 1);

`ifdef FRAMER_CRC8_EN
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD, S_CRC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD} state_t;
`endif

  state_t      r_state, w_state_next;
  logic [11:0] r_bit_cnt, w_bit_cnt_next;
  logic [6:0]  r_bit_idx, w_bit_idx_next;
  logic [15:0] r_shift, w_shift_next;
  logic [7:0]  r_hold, w_hold_next;
  logic        r_hold_full, w_hold_full_next;
  logic        r_hold_last, w_hold_last_next;
  logic        r_cur_last, w_cur_last_next;
  logic        r_out, w_out_next;
  logic        r_en, w_en_next;
  logic        r_underrun, w_underrun_next;
  logic        r_alive;
  logic        w_bit_end, w_last_acc, w_abort, w_ready, w_accept;
  logic        w_shift_bit, w_unload, w_finish;

`ifdef FRAMER_CRC8_EN
  logic [7:0] r_crc, w_crc_next;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] x;
    x = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
  endfunction
`endif

  assign w_bit_end  = (r_bit_cnt == BIT_LAST);
  assign w_last_acc = (r_hold_full && r_hold_last) || r_cur_last;
  // Starved byte boundary; s_ready is withheld so no byte is accepted on the aborting edge.
  assign w_abort    = (r_state == S_PAYLOAD) && w_bit_end && (r_bit_idx == 7'd7) &&
                      !r_cur_last && !r_hold_full;
  assign w_ready    = r_alive && !r_hold_full && !w_last_acc && !w_abort;
  assign w_accept   = s_valid && w_ready;

  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_hold_last_next = r_hold_last;
    w_cur_last_next  = r_cur_last;
    w_out_next       = r_out;
    w_en_next        = r_en;
    w_underrun_next  = 1'b0;
    w_shift_bit      = 1'b0;
    w_unload         = 1'b0;
    w_finish         = 1'b0;
`ifdef FRAMER_CRC8_EN
    w_crc_next       = r_crc;
`endif

    if (r_state != S_IDLE) begin
      w_bit_cnt_next = w_bit_end ? 12'd0 : r_bit_cnt + 12'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next   = S_PREAMBLE;
          w_bit_cnt_next = 12'd0;
          w_bit_idx_next = 7'd0;
          w_out_next     = 1'b1;
          w_en_next      = 1'b1;
`ifdef FRAMER_CRC8_EN
          w_crc_next     = 8'h00;
`endif
        end
      end
      S_PREAMBLE: begin
        if (w_bit_end) begin
          if (r_bit_idx == PRE_LAST) begin
            w_state_next   = S_SYNC;
            w_shift_next   = SYNC_WORD;
            w_out_next     = SYNC_WORD[15];
            w_bit_idx_next = 7'd0;
          end else begin
            w_bit_idx_next = r_bit_idx + 7'd1;
            w_out_next     = r_bit_idx[0];
          end
        end
      end
      S_SYNC: begin
        if (w_bit_end) begin
          if (r_bit_idx == 7'd15) w_unload = 1'b1;
          else                    w_shift_bit = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (w_bit_end) begin
          if (r_bit_idx == 7'd7) begin
            if (r_cur_last) begin
`ifdef FRAMER_CRC8_EN
              w_state_next   = S_CRC;
              w_shift_next   = {r_crc, 8'h00};
              w_out_next     = r_crc[7];
              w_bit_idx_next = 7'd0;
`else
              w_finish = 1'b1;
`endif
            end else if (r_hold_full) begin
              w_unload = 1'b1;
            end else begin
              w_finish        = 1'b1;
              w_underrun_next = 1'b1;
            end
          end else begin
            w_shift_bit = 1'b1;
          end
        end
      end
`ifdef FRAMER_CRC8_EN
      S_CRC: begin
        if (w_bit_end) begin
          if (r_bit_idx == 7'd7) w_finish = 1'b1;
          else                   w_shift_bit = 1'b1;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase

    if (w_shift_bit) begin
      w_shift_next   = r_shift << 1;
      w_out_next     = r_shift[14];
      w_bit_idx_next = r_bit_idx + 7'd1;
    end

    if (w_unload) begin
      w_state_next     = S_PAYLOAD;
      w_shift_next     = {r_hold, 8'h00};
      w_out_next       = r_hold[7];
      w_bit_idx_next   = 7'd0;
      w_hold_full_next = 1'b0;
      w_cur_last_next  = r_hold_last;
`ifdef FRAMER_CRC8_EN
      w_crc_next       = crc8_byte(r_crc, r_hold);
`endif
    end

    if (w_finish) begin
      w_state_next     = S_IDLE;
      w_bit_cnt_next   = 12'd0;
      w_bit_idx_next   = 7'd0;
      w_out_next       = 1'b0;
      w_en_next        = 1'b0;
      w_hold_full_next = 1'b0;
      w_hold_last_next = 1'b0;
      w_cur_last_next  = 1'b0;
    end

    // A load arriving on an unload edge wins: the new byte stays held.
    if (w_accept) begin
      w_hold_next      = s_data;
      w_hold_full_next = 1'b1;
      w_hold_last_next = s_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 12'd0;
      r_bit_idx   <= 7'd0;
      r_shift     <= 16'h0000;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_cur_last  <= 1'b0;
      r_out       <= 1'b0;
      r_en        <= 1'b0;
      r_underrun  <= 1'b0;
      r_alive     <= 1'b0;
`ifdef FRAMER_CRC8_EN
      r_crc       <= 8'h00;
`endif
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
      r_hold_last <= w_hold_last_next;
      r_cur_last  <= w_cur_last_next;
      r_out       <= w_out_next;
      r_en        <= w_en_next;
      r_underrun  <= w_underrun_next;
      r_alive     <= 1'b1;
`ifdef FRAMER_CRC8_EN
      r_crc       <= w_crc_next;
`endif
    end
  end

  assign s_ready      = w_ready;
  assign bit_data_out = r_out;
  assign bit_data_en  = r_en;
  assign busy         = (r_state != S_IDLE);
  assign underrun     = r_underrun;
endmodule

// File: tb/tb_bpsk_frame_tx.sv
// Scoreboard bench for bpsk_frame_tx: a default-parameter instance plus a BIT_PERIOD=2/PREAMBLE_LEN=2 instance.
// Stimulus pushes each frame's expected bit stream; a negedge monitor pops and compares every en-high cycle.
module tb_bpsk_frame_tx;
`ifdef FRAMER_CRC8_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tv = 1'b0;
  logic       tl = 1'b0;
  logic [7:0] td = 8'h00;
  logic       sel = 1'b0;

  logic v0, v1;
  logic rdy0, out0, en0, busy0, und0;
  logic rdy1, out1, en1, busy1, und1;
  logic m_rdy, m_out, m_en, m_busy, m_und;

  assign v0 = tv & ~sel;
  assign v1 = tv & sel;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_out  = sel ? out1  : out0;
  assign m_en   = sel ? en1   : en0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_und  = sel ? und1  : und0;

  always #5 clk = ~clk;

  bpsk_frame_tx u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(td), .s_valid(v0), .s_last(tl), .s_ready(rdy0),
    .bit_data_out(out0), .bit_data_en(en0), .busy(busy0), .underrun(und0)
  );

  bpsk_frame_tx #(.BIT_PERIOD(2), .PREAMBLE_LEN(2)) u_small (
    .clk(clk), .rst_n(rst_n), .s_data(td), .s_valid(v1), .s_last(tl), .s_ready(rdy1),
    .bit_data_out(out1), .bit_data_en(en1), .busy(busy1), .underrun(und1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      if (n_fails <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // Scoreboard queues: per-frame bit stream, bit count, hand-computed en-high cycles, abort flag.
  bit         q_bits [$];
  int         q_len  [$];
  int         q_cyc  [$];
  bit         q_abort[$];
  logic [7:0] pay [0:15];

  task automatic exp_frame(input int n, input bit aborted, input bit use_fixed,
                           input logic [7:0] fixed_crc, input int exp_cycles);
    int         nb;
    int         pl;
    logic [15:0] sw;
    logic [7:0] crc;
    logic [7:0] b;
    nb  = 0;
    pl  = sel ? 2 : 16;
    sw  = 16'hD391;
    crc = 8'h00;
    for (int i = 0; i < pl; i++) begin q_bits.push_back((i % 2) == 0); nb++; end
    for (int i = 15; i >= 0; i--) begin q_bits.push_back(sw[i]); nb++; end
    for (int k = 0; k < n; k++) begin
      b   = pay[k];
      crc = crc8(crc, b);
      for (int i = 7; i >= 0; i--) begin q_bits.push_back(b[i]); nb++; end
    end
    if (use_fixed) crc = fixed_crc;
`ifdef FRAMER_CRC8_EN
    if (!aborted) begin
      for (int i = 7; i >= 0; i--) begin q_bits.push_back(crc[i]); nb++; end
    end
`endif
    q_len.push_back(nb);
    q_cyc.push_back(exp_cycles);
    q_abort.push_back(aborted);
  endtask

  // Monitor
  bit in_frame = 1'b0;
  bit cur_bit, cur_abort, prev_und = 1'b0, tmpb;
  int bitn, cyc, nbits, en_cycles, exp_cyc, bp;
  int und_count = 0;

  always @(negedge clk) begin
    bp = sel ? 2 : 20;
    if (!rst_n) begin
      if (in_frame) begin
        for (int i = bitn + 1; i < nbits; i++) tmpb = q_bits.pop_front();
        in_frame = 1'b0;
      end
      check("reset_underrun", m_und, 0);
      check("reset_en", m_en, 0);
      prev_und = 1'b0;
    end else begin
      if (m_en && !in_frame) begin
        in_frame = 1'b1; bitn = 0; cyc = 0; en_cycles = 0;
        nbits = 0; exp_cyc = 0; cur_abort = 1'b0;
        if (q_len.size() != 0) begin
          nbits     = q_len.pop_front();
          exp_cyc   = q_cyc.pop_front();
          cur_abort = q_abort.pop_front();
          cur_bit   = q_bits.pop_front();
        end
      end
      if (m_en && in_frame) begin
        en_cycles++;
        if (bitn < nbits) begin
          check("frame_bit", m_out, cur_bit);
          cyc++;
          if (cyc == bp) begin
            cyc = 0;
            bitn++;
            if (bitn < nbits) cur_bit = q_bits.pop_front();
          end
        end
      end
      if (!m_en && in_frame) begin
        check("frame_en_cycles", en_cycles, exp_cyc);
        check("underrun_at_frame_end", m_und, cur_abort);
        check("busy_after_frame", m_busy, 0);
        check("idle_out_zero", m_out, 0);
        in_frame = 1'b0;
      end
      if (m_und) begin
        und_count++;
        check("underrun_one_cycle", prev_und, 0);
      end
      prev_und = m_und;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, output int waited);
    td = d; tl = last; tv = 1'b1; waited = 0;
    while (!m_rdy && waited < 3000) begin @(posedge clk); #1; waited++; end
    check("handshake_ready", m_rdy, 1);
    @(posedge clk); #1;
    tv = 1'b0; tl = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_busy && k < 5000) begin @(posedge clk); #1; k++; end
    check("frame_completes", m_busy, 0);
    wait_cycles(2);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", rdy0, 0);
    check("rst_out", out0, 0);
    check("rst_en", en0, 0);
    check("rst_busy", busy0, 0);
    check("rst_underrun", und0, 0);
    check("rst_ready_small", rdy1, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_before_first_edge", rdy0, 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", rdy0, 1);

    // Single byte A5: (16+16+8)*20 = 800 cycles
    pay[0] = 8'hA5;
    exp_frame(1, 1'b0, 1'b0, 8'h00, 800 + CRC_BITS * 20);
    send_byte(8'hA5, 1'b1, w);
    check("first_preamble_out", m_out, 1);
    check("first_preamble_en", m_en, 1);
    check("ready_low_after_last", m_rdy, 0);
    wait_idle();

    // Three bytes streamed: (16+16+24)*20 = 1120 cycles
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    exp_frame(3, 1'b0, 1'b0, 8'h00, 1120 + CRC_BITS * 20);
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h02, 1'b0, w);
    check("ready_low_while_held", m_rdy, 0);
    send_byte(8'h03, 1'b1, w);
    check("reopen_within_byte", (w <= 160), 1);
    check("ready_low_after_last3", m_rdy, 0);
    wait_idle();

    // Underrun: two bytes, third withheld: (16+16+16)*20 = 960 cycles then abort
    pay[0] = 8'hC3; pay[1] = 8'h5E;
    exp_frame(2, 1'b1, 1'b0, 8'h00, 960);
    send_byte(8'hC3, 1'b0, w);
    send_byte(8'h5E, 1'b0, w);
    wait_idle();
    check("ready_after_abort", m_rdy, 1);

    // "123456789": (16+16+72)*20 = 2080 cycles, CRC-8 0xF4 when enabled
    for (int k = 0; k < 9; k++) pay[k] = 8'h31 + 8'(k);
    exp_frame(9, 1'b0, 1'b1, 8'hF4, 2080 + CRC_BITS * 20);
    for (int k = 0; k < 9; k++) send_byte(pay[k], (k == 8), w);
    wait_idle();

    // Reset mid-SYNC discards the frame without an underrun pulse
    pay[0] = 8'h5A;
    exp_frame(1, 1'b0, 1'b0, 8'h00, 800 + CRC_BITS * 20);
    send_byte(8'h5A, 1'b1, w);
    wait_cycles(340);
    check("in_frame_before_reset", m_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", rdy0, 0);
    check("midrst_out", out0, 0);
    check("midrst_en", en0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_underrun", und0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    pay[0] = 8'h3C;
    exp_frame(1, 1'b0, 1'b0, 8'h00, 800 + CRC_BITS * 20);
    send_byte(8'h3C, 1'b1, w);
    check("restart_preamble_out", m_out, 1);
    wait_idle();

    // Small instance: BIT_PERIOD=2, PREAMBLE_LEN=2; 0xFF -> 26 bits = 52 cycles
    sel = 1'b1;
    wait_cycles(2);
    pay[0] = 8'hFF;
    exp_frame(1, 1'b0, 1'b0, 8'h00, 52 + CRC_BITS * 2);
    send_byte(8'hFF, 1'b1, w);
    check("small_first_out", m_out, 1);
    wait_idle();
    pay[0] = 8'h80; pay[1] = 8'h01;
    exp_frame(2, 1'b0, 1'b0, 8'h00, 68 + CRC_BITS * 2);
    send_byte(8'h80, 1'b0, w);
    send_byte(8'h01, 1'b1, w);
    wait_idle();

    check("underrun_count", und_count, 1);
    check("scoreboard_frames_left", q_len.size(), 0);
    check("scoreboard_bits_left", q_bits.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
